// File: rtl/riscv_crypto_aes_subword_seq_if.sv
// Request/response bundle between the crypto FU issue logic and the sequential SubWord engine.
// master = FU issue/result side, slave = the SubWord engine.
interface riscv_crypto_aes_subword_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_rs;
    logic        req_inv;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    modport master (
        output req_valid, req_rs, req_inv, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_rs, req_inv, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/riscv_crypto_aes_subword_seq.sv
// Sequential SubWord/InvSubWord: substitutes the four bytes of a word in place,
// LANES bytes per cycle, through a shared pool of combinational forward/inverse S-box lanes.
module riscv_crypto_aes_subword_seq #(
    parameter int unsigned LANES = 1
) (
    input logic                          g_clk,
    input logic                          g_resetn,
    riscv_crypto_aes_subword_seq_if.slave bus
);

    localparam int unsigned ITER     = 4 / LANES;
    localparam logic [1:0]  CNT_LAST = 2'(ITER - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("riscv_crypto_aes_subword_seq: LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic [31:0] work, work_nxt;
    logic        inv, inv_nxt;
    logic [31:0] work_sub;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    // Lane j substitutes byte cnt*LANES + j of work; other bytes pass through.
    always_comb begin
        logic [1:0] bsel;
        logic [7:0] lane_in;
        work_sub = work;
        bsel     = 2'b00;
        lane_in  = 8'h00;
        for (int j = 0; j < int'(LANES); j++) begin
            bsel    = 2'(32'(cnt) * LANES + 32'(j));
            lane_in = work[8*bsel +: 8];
            work_sub[8*bsel +: 8] = inv ? sbox_inv(lane_in) : sbox_fwd(lane_in);
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state <= IDLE;
            cnt   <= 2'b00;
            work  <= 32'h0000_0000;
            inv   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            work  <= work_nxt;
            inv   <= inv_nxt;
        end
    end

    // Next state and handshake outputs; a DONE-cycle request is accepted while the result drains.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        work_nxt      = work;
        inv_nxt       = inv;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;

        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    work_nxt  = bus.req_rs;
                    inv_nxt   = bus.req_inv;
                    cnt_nxt   = 2'b00;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                work_nxt = work_sub;
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = 2'b00;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                bus.req_ready = bus.rsp_ready;
                if (bus.rsp_ready) begin
                    if (bus.req_valid) begin
                        work_nxt  = bus.req_rs;
                        inv_nxt   = bus.req_inv;
                        cnt_nxt   = 2'b00;
                        state_nxt = BUSY;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 2'b00;
            end
        endcase

        // Abort wins over any handshake; the operand register is left as is.
        if (bus.flush) begin
            state_nxt = IDLE;
            cnt_nxt   = 2'b00;
            work_nxt  = work;
            inv_nxt   = inv;
        end
    end

    assign bus.rsp_data = work;

endmodule

// File: tb/tb_riscv_crypto_aes_subword_seq.sv
// Scoreboard bench for riscv_crypto_aes_subword_seq: one instance per legal LANES value,
// directed scenarios followed by random words with a DUT round-trip check.
module tb_riscv_crypto_aes_subword_seq;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam int BOUND = 64;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [31:0] req_rs [3];
    logic [2:0]  req_inv;
    logic [2:0]  flush;
    logic [2:0]  rsp_ready;
    wire  [2:0]  req_ready;
    wire  [2:0]  rsp_valid;
    wire  [31:0] rsp_data [3];

    logic [7:0]  isbox [256];
    logic [31:0] expq [$];
    int          checks;
    int          errors;
    int          cyc;

    // Instance g runs with LANES = 1 << g.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        riscv_crypto_aes_subword_seq_if bus ();
        assign bus.req_valid = req_valid[g];
        assign bus.req_rs    = req_rs[g];
        assign bus.req_inv   = req_inv[g];
        assign bus.flush     = flush[g];
        assign bus.rsp_ready = rsp_ready[g];
        assign req_ready[g]  = bus.req_ready;
        assign rsp_valid[g]  = bus.rsp_valid;
        assign rsp_data[g]   = bus.rsp_data;
        riscv_crypto_aes_subword_seq #(.LANES(1 << g)) dut (
            .g_clk    (clk),
            .g_resetn (rst_n),
            .bus      (bus.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_word(input logic [31:0] w, input logic iv);
        logic [31:0] r;
        for (int k = 0; k < 4; k++)
            r[8*k +: 8] = iv ? isbox[w[8*k +: 8]] : SBOX[w[8*k +: 8]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int d, input logic [31:0] rs, input logic iv,
                        input logic [31:0] exp, input bit push);
        int n;
        n = 0;
        req_valid[d] = 1'b1;
        req_rs[d]    = rs;
        req_inv[d]   = iv;
        while (req_ready[d] !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", {31'b0, req_ready[d]}, 32'd1);
        if (push) expq.push_back(exp);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d, output int n);
        n = 0;
        while (rsp_valid[d] !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", {31'b0, rsp_valid[d]}, 32'd1);
    endtask

    task automatic check_pop(input int d, input string tag);
        logic [31:0] e;
        if (expq.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = expq.pop_front();
            chk(tag, rsp_data[d], e);
        end
    endtask

    initial begin
        int          n;
        int          t1;
        int          seen;
        logic [31:0] rs;
        logic [31:0] mid;
        logic        iv;

        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        req_valid = 3'b000;
        req_inv   = 3'b000;
        flush     = 3'b000;
        rsp_ready = 3'b111;
        for (int d = 0; d < 3; d++) req_rs[d] = 32'h0;
        for (int i = 0; i < 256; i++) isbox[SBOX[i]] = 8'(i);

        // Reset state on every instance
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_req_ready", {31'b0, req_ready[d]}, 32'd1);
            chk("rst_rsp_valid", {31'b0, rsp_valid[d]}, 32'd0);
            chk("rst_rsp_data", rsp_data[d], 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Forward, LANES=1
        send(0, 32'h53020100, 1'b0, 32'hED777C63, 1'b1);
        wait_valid(0, n);
        chk("fwd_latency", 32'(n), 32'd4);
        check_pop(0, "fwd_data");
        @(negedge clk);

        // Inverse, LANES=2
        send(1, 32'hED777C63, 1'b1, 32'h53020100, 1'b1);
        wait_valid(1, n);
        chk("inv_latency", 32'(n), 32'd2);
        check_pop(1, "inv_data");
        @(negedge clk);
        send(1, 32'h00000000, 1'b1, 32'h52525252, 1'b1);
        wait_valid(1, n);
        check_pop(1, "inv_zero");
        @(negedge clk);

        // Backpressure, LANES=4
        rsp_ready[2] = 1'b0;
        send(2, 32'hFFFFFFFF, 1'b0, 32'h16161616, 1'b1);
        wait_valid(2, n);
        chk("bp_latency", 32'(n), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'b0, rsp_valid[2]}, 32'd1);
            chk("bp_data", rsp_data[2], 32'h16161616);
            chk("bp_req_ready", {31'b0, req_ready[2]}, 32'd0);
            @(negedge clk);
        end
        rsp_ready[2] = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, req_ready[2]}, 32'd1);
        check_pop(2, "bp_data_release");
        @(negedge clk);
        chk("bp_idle_valid", {31'b0, rsp_valid[2]}, 32'd0);
        chk("bp_idle_ready", {31'b0, req_ready[2]}, 32'd1);

        // Back-to-back, LANES=1
        req_valid[0] = 1'b1;
        req_rs[0]    = 32'h00000000;
        req_inv[0]   = 1'b0;
        expq.push_back(32'h63636363);
        @(negedge clk);
        req_rs[0] = 32'h01010101;
        expq.push_back(32'h7C7C7C7C);
        wait_valid(0, n);
        chk("b2b_latency1", 32'(n), 32'd4);
        t1 = cyc;
        chk("b2b_done_ready", {31'b0, req_ready[0]}, 32'd1);
        check_pop(0, "b2b_data1");
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("b2b_no_bubble", {31'b0, rsp_valid[0]}, 32'd0);
        wait_valid(0, n);
        chk("b2b_spacing", 32'(cyc - t1), 32'd5);
        check_pop(0, "b2b_data2");
        @(negedge clk);

        // Flush in BUSY, LANES=1
        send(0, 32'h53020100, 1'b0, 32'h0, 1'b0);
        flush[0] = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0;
        chk("flush_valid", {31'b0, rsp_valid[0]}, 32'd0);
        chk("flush_ready", {31'b0, req_ready[0]}, 32'd1);
        // A request presented together with flush in IDLE is dropped
        req_valid[0] = 1'b1;
        flush[0]     = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        flush[0]     = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid[0] !== 1'b0) seen++;
            @(negedge clk);
        end
        chk("flush_no_rsp", 32'(seen), 32'd0);

        // Reset pulse in BUSY, LANES=1
        send(0, 32'h53020100, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstb_valid", {31'b0, rsp_valid[0]}, 32'd0);
        chk("rstb_data", rsp_data[0], 32'h0);
        chk("rstb_ready", {31'b0, req_ready[0]}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, 32'h53020100, 1'b0, 32'hED777C63, 1'b1);
        wait_valid(0, n);
        chk("rstb_latency", 32'(n), 32'd4);
        check_pop(0, "rstb_data_after");
        @(negedge clk);

        // Random words and directions, then the DUT result sent back the other way
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 600; i++) begin
                rs = $urandom;
                iv = 1'($urandom_range(0, 1));
                send(d, rs, iv, ref_word(rs, iv), 1'b1);
                wait_valid(d, n);
                chk("rnd_latency", 32'(n), 32'(4 >> d));
                mid = rsp_data[d];
                check_pop(d, "rnd_data");
                @(negedge clk);
                send(d, mid, ~iv, rs, 1'b1);
                wait_valid(d, n);
                check_pop(d, "rnd_roundtrip");
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
